// File: rtl/pipeline_lane_balancer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_lane_balancer
// Purpose  : Dispatches triangle entries round-robin across NUM_LANES external
//            math lanes and merges their pixel streams into one stream. A frame
//            barrier guarantees exactly one output pixel per frame carries last
//            (metadata bit 0), and that it is the true final pixel of the frame.
//            Optional per-frame statistics are enabled by defining the macro
//            PIPELINE_LANE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_lane_balancer #(
    parameter int NUM_LANES  = 2,
    parameter int TRI_W      = 256,
    parameter int PIX_W      = 32,
    parameter int PIX_META_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             triangle_s_valid,
    output logic                             triangle_s_ready,
    input  logic [TRI_W-1:0]                 triangle_s_data,
    input  logic                             triangle_s_last,
    output logic [NUM_LANES-1:0]             lane_tri_m_valid,
    input  logic [NUM_LANES-1:0]             lane_tri_m_ready,
    output logic [TRI_W-1:0]                 lane_tri_m_data,
    output logic                             lane_tri_m_last,
    input  logic [NUM_LANES-1:0]             lane_pix_s_valid,
    output logic [NUM_LANES-1:0]             lane_pix_s_ready,
    input  logic [NUM_LANES*PIX_W-1:0]       lane_pix_s_data,
    input  logic [NUM_LANES*PIX_META_W-1:0]  lane_pix_s_metadata,
    input  logic [NUM_LANES-1:0]             lane_idle,
    output logic                             pixel_m_valid,
    input  logic                             pixel_m_ready,
    output logic [PIX_W-1:0]                 pixel_m_data,
    output logic [PIX_META_W-1:0]            pixel_m_metadata,
    output logic                             frame_busy
`ifdef PIPELINE_LANE_STATS_EN
    ,
    output logic [31:0]                      stat_pixels,
    output logic [31:0]                      stat_triangles,
    output logic [NUM_LANES*32-1:0]          stat_lane_busy,
    output logic                             stat_valid
`endif
);

    localparam int         c_IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    // First requester at or after start, wrapping modulo NUM_LANES.
    function automatic logic [c_IDX_W-1:0] f_rr_pick(
        input logic [NUM_LANES-1:0] req,
        input logic [c_IDX_W-1:0]   start
    );
        logic [2*NUM_LANES-1:0] rot;
        logic [2*NUM_LANES-1:0] sh;
        int                     off;
        int                     idx;
        rot = {req, req} >> start;
        off = 0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            sh = rot >> k;
            if (sh[0]) begin
                off = k;
            end
        end
        idx = int'(start) + off;
        if (idx >= NUM_LANES) begin
            idx = idx - NUM_LANES;
        end
        return c_IDX_W'(idx);
    endfunction

    // Lane index successor with wrap at NUM_LANES-1.
    function automatic logic [c_IDX_W-1:0] f_next(input logic [c_IDX_W-1:0] idx);
        if (int'(idx) >= NUM_LANES - 1) begin
            return '0;
        end
        return idx + c_IDX_W'(1);
    endfunction

    logic [0:0]            r_state;
    logic [c_IDX_W-1:0]    r_rr_tri;
    logic [c_IDX_W-1:0]    r_rr_pix;
    logic                  r_hold_valid;
    logic [PIX_W-1:0]      r_hold_data;
    logic [PIX_META_W-1:0] r_hold_meta;
    logic                  r_lane_seen_last;

    logic [0:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    w_rr_tri_nxt;
    logic [c_IDX_W-1:0]    w_rr_pix_nxt;
    logic                  w_hold_valid_nxt;
    logic [PIX_W-1:0]      w_hold_data_nxt;
    logic [PIX_META_W-1:0] w_hold_meta_nxt;
    logic                  w_lane_seen_last_nxt;

    logic [c_IDX_W-1:0]    w_tri_grant;
    logic [c_IDX_W-1:0]    w_pix_grant;
    logic                  w_run;
    logic                  w_tri_fire;
    logic                  w_any_pix;
    logic                  w_take;
    logic                  w_out_fire;
    logic                  w_frame_done;
    logic [PIX_W-1:0]      w_sel_data;
    logic [PIX_META_W-1:0] w_sel_meta;

    // Zero-latency triangle dispatch: broadcast data, one-hot valid to the granted lane.
    always_comb begin
        w_tri_grant      = f_rr_pick(lane_tri_m_ready, r_rr_tri);
        w_run            = (r_state == c_ST_RUN) && !rst;
        triangle_s_ready = w_run && (|lane_tri_m_ready);
        lane_tri_m_valid = (NUM_LANES'(1) << w_tri_grant)
                         & {NUM_LANES{triangle_s_valid && w_run}};
        lane_tri_m_data  = triangle_s_data;
        lane_tri_m_last  = triangle_s_last;
        w_tri_fire       = triangle_s_valid && triangle_s_ready;
    end

    // Pixel merge: a held pixel leaves only once its successor or the frame end is known,
    // so the frame-last flag can be applied to the genuinely final pixel.
    always_comb begin
        w_any_pix        = |lane_pix_s_valid;
        w_pix_grant      = f_rr_pick(lane_pix_s_valid, r_rr_pix);
        w_sel_data       = PIX_W'(lane_pix_s_data >> (int'(w_pix_grant) * PIX_W));
        w_sel_meta       = PIX_META_W'(lane_pix_s_metadata >> (int'(w_pix_grant) * PIX_META_W));
        w_frame_done     = (r_state == c_ST_DRAIN) && r_lane_seen_last
                         && (&lane_idle) && !w_any_pix;
        pixel_m_valid    = !rst && r_hold_valid && (w_any_pix || w_frame_done);
        w_out_fire       = pixel_m_valid && pixel_m_ready;
        w_take           = !rst && (!r_hold_valid || w_out_fire) && w_any_pix;
        lane_pix_s_ready = (NUM_LANES'(1) << w_pix_grant) & {NUM_LANES{w_take}};
        pixel_m_data     = r_hold_data;
        // Held metadata always has bit 0 cleared, so OR-ing inserts the frame-last flag.
        pixel_m_metadata = r_hold_meta | PIX_META_W'(w_frame_done);
        frame_busy       = (r_state == c_ST_DRAIN);
    end

    // Next-state for frame FSM, round-robin pointers and hold register.
    always_comb begin
        w_state_nxt          = r_state;
        w_rr_tri_nxt         = r_rr_tri;
        w_rr_pix_nxt         = r_rr_pix;
        w_hold_valid_nxt     = r_hold_valid;
        w_hold_data_nxt      = r_hold_data;
        w_hold_meta_nxt      = r_hold_meta;
        w_lane_seen_last_nxt = r_lane_seen_last;

        if (w_tri_fire) begin
            w_rr_tri_nxt = f_next(w_tri_grant);
            if (triangle_s_last) begin
                w_state_nxt = c_ST_DRAIN;
            end
        end

        if (w_take) begin
            w_hold_valid_nxt   = 1'b1;
            w_hold_data_nxt    = w_sel_data;
            w_hold_meta_nxt    = w_sel_meta;
            w_hold_meta_nxt[0] = 1'b0;
            w_rr_pix_nxt       = f_next(w_pix_grant);
            if (w_sel_meta[0]) begin
                w_lane_seen_last_nxt = 1'b1;
            end
        end else if (w_out_fire) begin
            w_hold_valid_nxt = 1'b0;
        end

        if (w_out_fire && w_frame_done) begin
            w_state_nxt          = c_ST_RUN;
            w_lane_seen_last_nxt = 1'b0;
            w_hold_valid_nxt     = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_ST_RUN;
            r_rr_tri         <= '0;
            r_rr_pix         <= '0;
            r_hold_valid     <= 1'b0;
            r_hold_data      <= '0;
            r_hold_meta      <= '0;
            r_lane_seen_last <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_rr_tri         <= w_rr_tri_nxt;
            r_rr_pix         <= w_rr_pix_nxt;
            r_hold_valid     <= w_hold_valid_nxt;
            r_hold_data      <= w_hold_data_nxt;
            r_hold_meta      <= w_hold_meta_nxt;
            r_lane_seen_last <= w_lane_seen_last_nxt;
        end
    end

`ifdef PIPELINE_LANE_STATS_EN
    logic        w_frame_end;
    logic [31:0] w_cnt_pix_nxt;
    logic [31:0] w_cnt_tri_nxt;
    logic [31:0] r_cnt_pix;
    logic [31:0] r_cnt_tri;

    // Per-frame counter increments; the snapshot includes the frame-last pixel itself.
    always_comb begin
        w_frame_end   = w_out_fire && w_frame_done;
        w_cnt_pix_nxt = r_cnt_pix + {31'd0, w_out_fire};
        w_cnt_tri_nxt = r_cnt_tri + {31'd0, w_tri_fire};
    end

    // Pixel/triangle counters, snapshot on frame end and one-cycle stat_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_pix      <= '0;
            r_cnt_tri      <= '0;
            stat_pixels    <= '0;
            stat_triangles <= '0;
            stat_valid     <= 1'b0;
        end else begin
            stat_valid <= w_frame_end;
            if (w_frame_end) begin
                stat_pixels    <= w_cnt_pix_nxt;
                stat_triangles <= w_cnt_tri_nxt;
                r_cnt_pix      <= '0;
                r_cnt_tri      <= '0;
            end else begin
                r_cnt_pix <= w_cnt_pix_nxt;
                r_cnt_tri <= w_cnt_tri_nxt;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_busy
            logic [31:0] r_cnt_busy;
            logic [31:0] r_stat_busy;
            logic [31:0] w_busy_nxt;

            assign w_busy_nxt = r_cnt_busy + {31'd0, !lane_idle[gi]};

            // Busy-cycle counter for this lane, snapshot on frame end.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt_busy  <= '0;
                    r_stat_busy <= '0;
                end else if (w_frame_end) begin
                    r_stat_busy <= w_busy_nxt;
                    r_cnt_busy  <= '0;
                end else begin
                    r_cnt_busy <= w_busy_nxt;
                end
            end

            assign stat_lane_busy[gi*32 +: 32] = r_stat_busy;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_lane_balancer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_lane_balancer
// Purpose  : Directed scoreboard bench for pipeline_lane_balancer (NUM_LANES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_lane_balancer;

    localparam int NL = 2;
    localparam int TW = 256;
    localparam int PW = 32;
    localparam int MW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             triangle_s_valid;
    logic             triangle_s_ready;
    logic [TW-1:0]    triangle_s_data;
    logic             triangle_s_last;
    logic [NL-1:0]    lane_tri_m_valid;
    logic [NL-1:0]    lane_tri_m_ready;
    logic [TW-1:0]    lane_tri_m_data;
    logic             lane_tri_m_last;
    logic [NL-1:0]    lane_pix_s_valid;
    logic [NL-1:0]    lane_pix_s_ready;
    logic [NL*PW-1:0] lane_pix_s_data;
    logic [NL*MW-1:0] lane_pix_s_metadata;
    logic [NL-1:0]    lane_idle;
    logic             pixel_m_valid;
    logic             pixel_m_ready;
    logic [PW-1:0]    pixel_m_data;
    logic [MW-1:0]    pixel_m_metadata;
    logic             frame_busy;
`ifdef PIPELINE_LANE_STATS_EN
    logic [31:0]      stat_pixels;
    logic [31:0]      stat_triangles;
    logic [NL*32-1:0] stat_lane_busy;
    logic             stat_valid;
    int               n_stat_pulses = 0;
`endif

    always #5 clk = ~clk;

    pipeline_lane_balancer #(
        .NUM_LANES  (NL),
        .TRI_W      (TW),
        .PIX_W      (PW),
        .PIX_META_W (MW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .triangle_s_valid    (triangle_s_valid),
        .triangle_s_ready    (triangle_s_ready),
        .triangle_s_data     (triangle_s_data),
        .triangle_s_last     (triangle_s_last),
        .lane_tri_m_valid    (lane_tri_m_valid),
        .lane_tri_m_ready    (lane_tri_m_ready),
        .lane_tri_m_data     (lane_tri_m_data),
        .lane_tri_m_last     (lane_tri_m_last),
        .lane_pix_s_valid    (lane_pix_s_valid),
        .lane_pix_s_ready    (lane_pix_s_ready),
        .lane_pix_s_data     (lane_pix_s_data),
        .lane_pix_s_metadata (lane_pix_s_metadata),
        .lane_idle           (lane_idle),
        .pixel_m_valid       (pixel_m_valid),
        .pixel_m_ready       (pixel_m_ready),
        .pixel_m_data        (pixel_m_data),
        .pixel_m_metadata    (pixel_m_metadata),
        .frame_busy          (frame_busy)
`ifdef PIPELINE_LANE_STATS_EN
        ,
        .stat_pixels         (stat_pixels),
        .stat_triangles      (stat_triangles),
        .stat_lane_busy      (stat_lane_busy),
        .stat_valid          (stat_valid)
`endif
    );

    typedef struct packed {
        logic [PW-1:0] d;
        logic [MW-1:0] m;
    } pix_t;

    pix_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   tri_tag = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops an expectation on every output handshake and
    // checks that a stalled output holds steady.
    initial begin : monitor
        pix_t          e;
        logic          stalled;
        logic [PW-1:0] st_d;
        logic [MW-1:0] st_m;
        stalled = 1'b0;
        st_d    = '0;
        st_m    = '0;
        forever begin
            @(negedge clk);
`ifdef PIPELINE_LANE_STATS_EN
            if (stat_valid) n_stat_pulses++;
`endif
            if (stalled && !rst) begin
                check("stall_valid", pixel_m_valid, 1'b1);
                check("stall_data", pixel_m_data, st_d);
                check("stall_meta", pixel_m_metadata, st_m);
            end
            stalled = 1'b0;
            if (!rst && pixel_m_valid) begin
                if (!pixel_m_ready) begin
                    stalled = 1'b1;
                    st_d    = pixel_m_data;
                    st_m    = pixel_m_metadata;
                end else if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pixel: got data %0h meta %0h with empty scoreboard",
                             pixel_m_data, pixel_m_metadata);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", pixel_m_data, e.d);
                    check("pix_meta", pixel_m_metadata, e.m);
                end
            end
        end
    end

    task automatic send_tri(input logic last, input logic [NL-1:0] exp_lane);
        int guard;
        guard            = 0;
        tri_tag          = tri_tag + 1;
        triangle_s_valid = 1'b1;
        triangle_s_data  = {8{32'hA5000000 | 32'(tri_tag)}};
        triangle_s_last  = last;
        @(negedge clk);
        while (!triangle_s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("tri_ready", triangle_s_ready, 1'b1);
        check("tri_lane", lane_tri_m_valid, exp_lane);
        check("tri_data", lane_tri_m_data[63:0], triangle_s_data[63:0]);
        check("tri_last", lane_tri_m_last, last);
        tick();
        triangle_s_valid = 1'b0;
        triangle_s_last  = 1'b0;
    endtask

    task automatic send_pix(input int lane, input logic [PW-1:0] d, input logic [MW-1:0] m);
        int   guard;
        logic rdy;
        guard               = 0;
        lane_pix_s_data     = {NL{~d}};
        lane_pix_s_metadata = {NL{~m}};
        if (lane == 0) begin
            lane_pix_s_valid             = 2'b01;
            lane_pix_s_data[PW-1:0]      = d;
            lane_pix_s_metadata[MW-1:0]  = m;
        end else begin
            lane_pix_s_valid             = 2'b10;
            lane_pix_s_data[2*PW-1:PW]   = d;
            lane_pix_s_metadata[2*MW-1:MW] = m;
        end
        @(negedge clk);
        rdy = (lane == 0) ? lane_pix_s_ready[0] : lane_pix_s_ready[1];
        while (!rdy && guard < 50) begin
            @(negedge clk);
            rdy = (lane == 0) ? lane_pix_s_ready[0] : lane_pix_s_ready[1];
            guard++;
        end
        if (!rdy) begin
            n_total++;
            $display("FAIL pix_accept_timeout: lane %0d data %0h never accepted", lane, d);
        end
        tick();
        lane_pix_s_valid = '0;
    endtask

    task automatic send_pair(input logic [PW-1:0] d0, input logic [MW-1:0] m0,
                             input logic [PW-1:0] d1, input logic [MW-1:0] m1);
        logic [NL-1:0] pend;
        logic [NL-1:0] done;
        int            guard;
        pend                = 2'b11;
        guard               = 0;
        lane_pix_s_valid    = pend;
        lane_pix_s_data     = {d1, d0};
        lane_pix_s_metadata = {m1, m0};
        while (pend != 0 && guard < 50) begin
            @(negedge clk);
            done = pend & lane_pix_s_ready;
            tick();
            pend             = pend & ~done;
            lane_pix_s_valid = pend;
            guard++;
        end
        if (pend != 0) begin
            n_total++;
            $display("FAIL pair_accept_timeout: pending lanes %b", pend);
        end
        lane_pix_s_valid = '0;
    endtask

    task automatic finish_frame();
        int guard;
        guard     = 0;
        lane_idle = '1;
        @(negedge clk);
        while (frame_busy && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("frame_end_busy", frame_busy, 1'b0);
        tick();
        lane_idle = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int guard;
        rst                 = 1'b1;
        triangle_s_valid    = 1'b0;
        triangle_s_data     = '0;
        triangle_s_last     = 1'b0;
        lane_tri_m_ready    = 2'b11;
        lane_pix_s_valid    = '0;
        lane_pix_s_data     = '0;
        lane_pix_s_metadata = '0;
        lane_idle           = '0;
        pixel_m_ready       = 1'b1;
        repeat (3) tick();

        // Reset state.
        @(negedge clk);
        check("rst_tri_ready", triangle_s_ready, 1'b0);
        check("rst_pix_valid", pixel_m_valid, 1'b0);
        check("rst_pix_ready", lane_pix_s_ready, 2'b00);
        check("rst_busy", frame_busy, 1'b0);
        tick();
        rst = 1'b0;

        // Frame 1: four triangles round-robin 0,1,0,1; the last moves to DRAIN.
        send_tri(1'b0, 2'b01);
        send_tri(1'b0, 2'b10);
        send_tri(1'b0, 2'b01);
        send_tri(1'b1, 2'b10);
        triangle_s_valid = 1'b1;
        @(negedge clk);
        check("drain_busy", frame_busy, 1'b1);
        check("drain_tri_ready", triangle_s_ready, 1'b0);
        check("drain_tri_valid", lane_tri_m_valid, 2'b00);
        tick();
        triangle_s_valid = 1'b0;
        exp_q.push_back('{d: 32'h11, m: 8'h40});
        exp_q.push_back('{d: 32'h22, m: 8'h81});
        send_pix(0, 32'h11, 8'h40);
        send_pix(1, 32'h22, 8'h81);
        finish_frame();

        // Frame 2: lane 1 not ready, all three triangles go to lane 0.
        lane_tri_m_ready = 2'b01;
        send_tri(1'b0, 2'b01);
        send_tri(1'b0, 2'b01);
        send_tri(1'b1, 2'b01);
        lane_tri_m_ready = 2'b11;
        // Lane-level last on B is not the frame end: only D carries last.
        exp_q.push_back('{d: 32'hA, m: 8'h10});
        exp_q.push_back('{d: 32'hB, m: 8'h20});
        exp_q.push_back('{d: 32'hC, m: 8'h30});
        exp_q.push_back('{d: 32'hD, m: 8'h41});
        send_pix(0, 32'hA, 8'h10);
        send_pix(0, 32'hB, 8'h21);
        send_pix(1, 32'hC, 8'h30);
        send_pix(1, 32'hD, 8'h40);
        finish_frame();

        // Frame 3: rr_tri resumes at lane 1; output stalled 5 cycles mid-stream;
        // simultaneous lane pixels arbitrate from rr_pix (lane 1 first after E).
        send_tri(1'b1, 2'b10);
        exp_q.push_back('{d: 32'hE,  m: 8'h50});
        exp_q.push_back('{d: 32'hF1, m: 8'h62});
        exp_q.push_back('{d: 32'hF0, m: 8'h70});
        exp_q.push_back('{d: 32'h88, m: 8'h81});
        fork
            begin
                send_pix(0, 32'hE, 8'h50);
                send_pair(32'hF0, 8'h70, 32'hF1, 8'h62);
                send_pix(1, 32'h88, 8'h81);
            end
            begin
                tick();
                tick();
                pixel_m_ready = 1'b0;
                repeat (5) tick();
                pixel_m_ready = 1'b1;
            end
        join
        finish_frame();

        // Reset in DRAIN with a held pixel: all discarded, dispatch restarts at lane 0.
        send_tri(1'b1, 2'b01);
        send_pix(0, 32'h99, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pix_valid", pixel_m_valid, 1'b0);
        check("post_rst_busy", frame_busy, 1'b0);
        check("post_rst_tri_valid", lane_tri_m_valid, 2'b00);
        tick();
        send_tri(1'b1, 2'b01);
        exp_q.push_back('{d: 32'hAA, m: 8'h01});
        send_pix(0, 32'hAA, 8'h01);
        finish_frame();

`ifdef PIPELINE_LANE_STATS_EN
        begin
            int pulses_before;
            pulses_before = n_stat_pulses;
            send_tri(1'b0, 2'b10);
            send_tri(1'b0, 2'b01);
            send_tri(1'b1, 2'b10);
            for (int i = 0; i < 10; i++) begin
                exp_q.push_back('{d: 32'h100 + 32'(i), m: (i == 9) ? 8'h01 : 8'h00});
            end
            for (int i = 0; i < 10; i++) begin
                send_pix(i % 2, 32'h100 + 32'(i), (i == 9) ? 8'h01 : 8'h00);
            end
            finish_frame();
            tick();
            check("stat_triangles", stat_triangles, 32'd3);
            check("stat_pixels", stat_pixels, 32'd10);
            check("stat_pulses", 64'(n_stat_pulses - pulses_before), 64'd1);
        end
`endif

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
